// File: rtl/skew_fifo_bank_pkg.sv
// Shared constants and FSM encoding for the skewed five-lane FIFO bank.
package skew_fifo_pkg;

  localparam int N     = 32;
  localparam int LANES = 5;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRAIN = 2'b01,
    TAIL  = 2'b10
  } state_t;

endpackage

// File: rtl/skew_fifo_bank_if.sv
// Write/drain bus of skew_fifo_bank; SKEW_FIFO_OVF_EN adds the sticky ovf vector.
interface skew_fifo_bank_if;
  import skew_fifo_pkg::*;

  logic [N-1:0]     wr_data;
  logic [2:0]       wr_lane;
  logic             wr_valid;
  logic             start;
  logic [N-1:0]     row0;
  logic [N-1:0]     row1;
  logic [N-1:0]     row2;
  logic [N-1:0]     row3;
  logic [N-1:0]     row4;
  logic [LANES-1:0] row_valid;
  logic [LANES-1:0] full;
  logic             busy;
  logic             done;
`ifdef SKEW_FIFO_OVF_EN
  logic [LANES-1:0] ovf;

  modport master (
    output wr_data, wr_lane, wr_valid, start,
    input  row0, row1, row2, row3, row4, row_valid, full, busy, done, ovf
  );
  modport slave (
    input  wr_data, wr_lane, wr_valid, start,
    output row0, row1, row2, row3, row4, row_valid, full, busy, done, ovf
  );
`else
  modport master (
    output wr_data, wr_lane, wr_valid, start,
    input  row0, row1, row2, row3, row4, row_valid, full, busy, done
  );
  modport slave (
    input  wr_data, wr_lane, wr_valid, start,
    output row0, row1, row2, row3, row4, row_valid, full, busy, done
  );
`endif

endinterface

// File: rtl/skew_fifo_bank_lane_fifo.sv
// Single lane FIFO: register-array storage, registered dout that reads zero when not popping.
module lane_fifo
  import skew_fifo_pkg::*;
(
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic [N-1:0] din,
  input  logic         pop,
  output logic [N-1:0] dout,
  output logic         empty,
  output logic         full
);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  // Pop only sees current contents, so a same-cycle push never falls through.
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      dout  <= do_pop ? mem[rd_ptr] : '0;
    end
  end

endmodule

// File: rtl/skew_fifo_bank.sv
// Five-lane FIFO bank draining into systolic-array rows with a one-cycle-per-lane skew.
// Optional feature macro: SKEW_FIFO_OVF_EN (sticky per-lane overflow flags on bus.ovf).
module skew_fifo_bank
  import skew_fifo_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  skew_fifo_bank_if.slave  bus
);

  state_t           state;
  state_t           state_nx;
  logic [2:0]       sc;
  logic [2:0]       sc_nx;
  logic [2:0]       tc;
  logic [LANES-1:0] push;
  logic [LANES-1:0] pop_p0;
  logic [LANES-1:0] empty;
  logic [LANES-1:0] full;
  logic [LANES-1:0] rv_p1;
  logic [N-1:0]     row_p1 [LANES];

  assign sc_nx = (sc == 3'(LANES-1)) ? sc : sc + 3'd1;

  // Write decode: lane codes at or above LANES match no lane and are dropped.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign push[i] = bus.wr_valid && (bus.wr_lane == 3'(i));

    lane_fifo u_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (push[i]),
      .din   (bus.wr_data),
      .pop   (pop_p0[i]),
      .dout  (row_p1[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      sc    <= '0;
      tc    <= '0;
    end else begin
      state <= state_nx;
      sc    <= (state == DRAIN) ? sc_nx : 3'd0;
      tc    <= (state == TAIL) ? tc + 3'd1 : 3'd0;
    end
  end

  // Leave DRAIN once the last lane is enabled from the next cycle on and nothing is buffered.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = DRAIN;
      DRAIN:   if ((sc_nx == 3'(LANES-1)) && (&empty)) state_nx = TAIL;
      TAIL:    if (tc == 3'(LANES-2)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == TAIL) && (tc == 3'(LANES-2));
    pop_p0   = '0;
    for (int i = 0; i < LANES; i++) begin
      pop_p0[i] = (state == DRAIN) && (sc >= 3'(i)) && !empty[i];
    end
  end

  // p0 -> p1: pop decision becomes the registered row-valid flag beside lane dout.
  always_ff @(posedge clk) begin
    if (clr) rv_p1 <= '0;
    else     rv_p1 <= pop_p0;
  end

  assign bus.row0      = row_p1[0];
  assign bus.row1      = row_p1[1];
  assign bus.row2      = row_p1[2];
  assign bus.row3      = row_p1[3];
  assign bus.row4      = row_p1[4];
  assign bus.row_valid = rv_p1;
  assign bus.full      = full;

`ifdef SKEW_FIFO_OVF_EN
  logic [LANES-1:0] ovf_q;

  always_ff @(posedge clk) begin
    if (clr) ovf_q <= '0;
    else     ovf_q <= ovf_q | (push & full);
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_skew_fifo_bank.sv
// Directed bench for skew_fifo_bank: cycle table plus hand sequences for overflow and continuous drain.
module tb_skew_fifo_bank;
  import skew_fifo_pkg::*;

  typedef struct {
    logic                wv;
    logic [2:0]          ln;
    logic [31:0]         d;
    logic                st;
    logic                cl;
    logic [4:0]          rv;
    logic                bz;
    logic                dn;
    logic [4:0]          fl;
    logic [4:0][31:0]    r;
  } vec_t;

  logic clk = 1'b0;
  logic clr;
  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t vq[$];

  skew_fifo_bank_if bus ();

  skew_fifo_bank dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [4:0][31:0] rows_now;
  assign rows_now = {bus.row4, bus.row3, bus.row2, bus.row1, bus.row0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic wv, input logic [2:0] ln, input logic [31:0] d,
                     input logic st, input logic cl, input logic [4:0] rv,
                     input logic bz, input logic dn,
                     input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                     input logic [31:0] r3, input logic [31:0] r4);
    vec_t v;
    v.wv = wv; v.ln = ln; v.d = d; v.st = st; v.cl = cl;
    v.rv = rv; v.bz = bz; v.dn = dn; v.fl = 5'b0;
    v.r  = {r4, r3, r2, r1, r0};
    vq.push_back(v);
  endtask

  task automatic wr(input logic [2:0] ln, input logic [31:0] d);
    add(1'b1, ln, d, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic cy(input logic st, input logic cl, input logic [4:0] rv, input logic bz, input logic dn,
                    input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                    input logic [31:0] r3, input logic [31:0] r4);
    add(1'b0, 3'd0, 32'd0, st, cl, rv, bz, dn, r0, r1, r2, r3, r4);
  endtask

  task automatic empty_drain();
    cy(1, 0, 5'b0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) cy(0, 0, 5'b0, 1, 0, 0, 0, 0, 0, 0);
    cy(0, 0, 5'b0, 1, 1, 0, 0, 0, 0, 0);
    cy(0, 0, 5'b0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int first_c;
    int last_c;
    logic seen;
    logic [31:0] exp4 [9];

    clr = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_lane  = 3'd0;
    bus.wr_data  = 32'd0;
    bus.start    = 1'b0;

    // Reset state
    cy(0, 1, 5'b0, 0, 0, 0, 0, 0, 0, 0);
    cy(0, 1, 5'b0, 0, 0, 0, 0, 0, 0, 0);
    // Two words per lane, skewed drain
    for (int i = 0; i < 5; i++) wr(3'(i), 32'h10 + i);
    for (int i = 0; i < 5; i++) wr(3'(i), 32'h20 + i);
    cy(1, 0, 5'b00000, 1, 0, 0,     0,     0,     0,     0);
    cy(0, 0, 5'b00001, 1, 0, 'h10,  0,     0,     0,     0);
    cy(0, 0, 5'b00011, 1, 0, 'h20,  'h11,  0,     0,     0);
    cy(0, 0, 5'b00110, 1, 0, 0,     'h21,  'h12,  0,     0);
    cy(0, 0, 5'b01100, 1, 0, 0,     0,     'h22,  'h13,  0);
    cy(0, 0, 5'b11000, 1, 0, 0,     0,     0,     'h23,  'h14);
    cy(0, 0, 5'b10000, 1, 0, 0,     0,     0,     0,     'h24);
    for (int k = 7; k <= 9; k++) cy(0, 0, 5'b0, 1, 0, 0, 0, 0, 0, 0);
    cy(0, 0, 5'b0, 1, 1, 0, 0, 0, 0, 0);
    cy(0, 0, 5'b0, 0, 0, 0, 0, 0, 0, 0);
    // Out-of-range lane codes, then a drain of an empty bank
    wr(3'd5, 32'hAAAA0005);
    wr(3'd6, 32'hAAAA0006);
    wr(3'd7, 32'hAAAA0007);
    empty_drain();
    // clr (with start) mid-drain
    wr(3'd0, 32'hA0);
    wr(3'd0, 32'hA1);
    wr(3'd0, 32'hA2);
    wr(3'd3, 32'hB3);
    cy(1, 0, 5'b00000, 1, 0, 0,     0, 0, 0, 0);
    cy(0, 0, 5'b00001, 1, 0, 'hA0,  0, 0, 0, 0);
    cy(1, 1, 5'b00000, 0, 0, 0,     0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cy(0, 0, 5'b0, 0, 0, 0, 0, 0, 0, 0);
    empty_drain();

    for (int v = 0; v < vq.size(); v++) begin
      bus.wr_valid = vq[v].wv;
      bus.wr_lane  = vq[v].ln;
      bus.wr_data  = vq[v].d;
      bus.start    = vq[v].st;
      clr          = vq[v].cl;
      tick();
      chk("rows",      v, 160'(rows_now),      160'(vq[v].r));
      chk("row_valid", v, 160'(bus.row_valid), 160'(vq[v].rv));
      chk("busy",      v, 160'(bus.busy),      160'(vq[v].bz));
      chk("done",      v, 160'(bus.done),      160'(vq[v].dn));
      chk("full",      v, 160'(bus.full),      160'(vq[v].fl));
    end
    bus.wr_valid = 1'b0;
    bus.start    = 1'b0;
    clr          = 1'b0;

    // Lane 2 overflow: 16 accepted, 17th dropped
    for (int k = 0; k < 17; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_lane  = 3'd2;
      bus.wr_data  = (k == 16) ? 32'hDEAD : 32'h200 + k;
      tick();
      if (k == 14) chk("t2_full_15", k, 160'(bus.full), 160'(5'b00000));
      if (k == 15) chk("t2_full_16", k, 160'(bus.full), 160'(5'b00100));
`ifdef SKEW_FIFO_OVF_EN
      if (k == 15) chk("t2_ovf_16", k, 160'(bus.ovf), 160'(5'b00000));
`endif
    end
    chk("t2_full_17", 16, 160'(bus.full), 160'(5'b00100));
`ifdef SKEW_FIFO_OVF_EN
    chk("t2_ovf_17", 16, 160'(bus.ovf), 160'(5'b00100));
`endif
    bus.wr_valid = 1'b0;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    got  = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (bus.row_valid[2]) begin
        chk("t2_word", got, 160'(bus.row2), 160'(32'h200 + got));
        got++;
      end
      if (bus.done) seen = 1'b1;
    end
    chk("t2_count", 0, 160'(got), 160'(16));
    chk("t2_done", 0, 160'(seen), 160'(1'b1));
    chk("t2_full_after", 0, 160'(bus.full), 160'(5'b00000));
`ifdef SKEW_FIFO_OVF_EN
    chk("t2_ovf_sticky", 0, 160'(bus.ovf), 160'(5'b00100));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t2_ovf_clr", 0, 160'(bus.ovf), 160'(5'b00000));
`endif

    // Lane 1 refilled every cycle while it drains
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 3; k++) exp4[k] = 32'h300 + k;
    for (int k = 0; k < 6; k++) exp4[3 + k] = 32'h310 + k;
    for (int k = 0; k < 3; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_lane  = 3'd1;
      bus.wr_data  = 32'h300 + k;
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    got     = 0;
    seen    = 1'b0;
    first_c = -1;
    last_c  = -1;
    for (int c = 0; c < 40 && !seen; c++) begin
      bus.wr_valid = (c >= 1 && c <= 6);
      bus.wr_lane  = 3'd1;
      bus.wr_data  = 32'h310 + 32'(c) - 32'd1;
      tick();
      if (bus.row_valid[1]) begin
        if (got < 9) chk("t4_word", got, 160'(bus.row1), 160'(exp4[got]));
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      if (bus.done) seen = 1'b1;
    end
    bus.wr_valid = 1'b0;
    chk("t4_count", 0, 160'(got), 160'(9));
    chk("t4_contiguous", 0, 160'(last_c - first_c + 1), 160'(9));
    chk("t4_done", 0, 160'(seen), 160'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
